// File: rtl/alsu_arbiter_if.sv
// Bundle of the two requester command/response channels, the ALSU drive/return
// lines and the busy flag shared between alsu_arbiter and its environment.
interface alsu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_cmd;
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_cmd;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [5:0]  rsp0_result;
    logic        rsp0_err;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [5:0]  rsp1_result;
    logic        rsp1_err;

    logic [2:0]  alsu_A;
    logic [2:0]  alsu_B;
    logic [2:0]  alsu_opcode;
    logic [6:0]  alsu_ctrl;
    logic [5:0]  alsu_out;
    logic        busy;

    modport master (
        output req0_valid, req0_cmd, req1_valid, req1_cmd,
        output rsp0_ready, rsp1_ready, alsu_out,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_err,
        input  rsp1_valid, rsp1_result, rsp1_err,
        input  alsu_A, alsu_B, alsu_opcode, alsu_ctrl, busy
    );

    modport slave (
        input  req0_valid, req0_cmd, req1_valid, req1_cmd,
        input  rsp0_ready, rsp1_ready, alsu_out,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_err,
        output rsp1_valid, rsp1_result, rsp1_err,
        output alsu_A, alsu_B, alsu_opcode, alsu_ctrl, busy
    );
endinterface

// File: rtl/alsu_arbiter.sv
// Round-robin arbiter sharing one pipelined ALSU between two requesters; one
// command in flight, illegal commands answered locally with an error response.
module alsu_arbiter #(
    parameter int LAT   = 2,
    parameter int CMD_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    alsu_arbiter_if.slave bus
);
    localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CMD_W-1:0] cmd_reg;
    logic [CMD_W-1:0] inc_cmd;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       result_reg;
    logic             err_reg;
    logic             owner;
    logic             rr_last;
    logic             winner;
    logic             grant_valid;
    logic             illegal;
    logic [2:0]       inc_op;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        winner          = 1'b0;
        grant_valid     = 1'b0;
        inc_cmd         = bus.req0_cmd;
        inc_op          = '0;
        illegal         = 1'b0;
        bus.req0_ready  = 1'b0;
        bus.req1_ready  = 1'b0;
        bus.rsp0_valid  = 1'b0;
        bus.rsp0_result = '0;
        bus.rsp0_err    = 1'b0;
        bus.rsp1_valid  = 1'b0;
        bus.rsp1_result = '0;
        bus.rsp1_err    = 1'b0;
        bus.alsu_A      = '0;
        bus.alsu_B      = '0;
        bus.alsu_opcode = '0;
        bus.alsu_ctrl   = '0;
        bus.busy        = (state != IDLE);

        case (state)
            IDLE: begin
                // tie goes to the requester that was not served last
                if (bus.req0_valid && bus.req1_valid) winner = ~rr_last;
                else                                  winner = bus.req1_valid;
                // ready is masked while reset is held so nothing reads as accepted
                grant_valid    = rst && (bus.req0_valid || bus.req1_valid);
                inc_cmd        = winner ? bus.req1_cmd : bus.req0_cmd;
                inc_op         = inc_cmd[15:13];
                illegal        = (inc_op == 3'b110) || (inc_op == 3'b111) ||
                                 ((inc_cmd[3] || inc_cmd[2]) && (inc_op[2:1] != 2'b00));
                bus.req0_ready = grant_valid && !winner;
                bus.req1_ready = grant_valid && winner;
                if (grant_valid) state_nx = illegal ? RESP : ISSUE;
            end
            ISSUE: begin
                bus.alsu_opcode = cmd_reg[15:13];
                bus.alsu_A      = cmd_reg[12:10];
                bus.alsu_B      = cmd_reg[9:7];
                bus.alsu_ctrl   = cmd_reg[6:0];
                if (cnt == '0) state_nx = RESP;
            end
            RESP: begin
                if (!owner) begin
                    bus.rsp0_valid  = 1'b1;
                    bus.rsp0_result = result_reg;
                    bus.rsp0_err    = err_reg;
                    if (bus.rsp0_ready) state_nx = IDLE;
                end else begin
                    bus.rsp1_valid  = 1'b1;
                    bus.rsp1_result = result_reg;
                    bus.rsp1_err    = err_reg;
                    if (bus.rsp1_ready) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_reg    <= '0;
            cnt        <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
            owner      <= 1'b0;
            rr_last    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cmd_reg    <= inc_cmd;
                        owner      <= winner;
                        rr_last    <= winner;
                        cnt        <= CNT_W'(LAT);
                        result_reg <= '0;
                        err_reg    <= illegal;
                    end
                end
                ISSUE: begin
                    // operands held LAT+1 cycles so the registered ALSU output is settled here
                    if (cnt == '0) begin
                        result_reg <= bus.alsu_out;
                        err_reg    <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alsu_arbiter.sv
// Directed bench for alsu_arbiter with a two-stage registered ALSU model.
module tb_alsu_arbiter;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    alsu_arbiter_if bus ();

    alsu_arbiter #(.LAT(2), .CMD_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALSU model: input register then output register
    logic [2:0] m_a, m_b, m_op;
    logic [6:0] m_ctrl;

    function automatic logic [5:0] alsu_f(input logic [2:0] op, input logic [2:0] a,
                                          input logic [2:0] b, input logic [6:0] ctrl);
        case (op)
            3'b000:  alsu_f = ctrl[3] ? {5'b0, &a} : ctrl[2] ? {5'b0, &b} : {3'b0, a & b};
            3'b001:  alsu_f = ctrl[3] ? {5'b0, ^a} : ctrl[2] ? {5'b0, ^b} : {3'b0, a ^ b};
            3'b010:  alsu_f = {3'b0, a} + {3'b0, b} + {5'b0, ctrl[6]};
            3'b011:  alsu_f = {3'b0, a} * {3'b0, b};
            default: alsu_f = '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_a <= '0; m_b <= '0; m_op <= '0; m_ctrl <= '0;
            bus.alsu_out <= '0;
        end else begin
            m_a <= bus.alsu_A; m_b <= bus.alsu_B; m_op <= bus.alsu_opcode; m_ctrl <= bus.alsu_ctrl;
            bus.alsu_out <= alsu_f(m_op, m_a, m_b, m_ctrl);
        end
    end

    localparam logic [15:0] CMD_ADD  = {3'b010, 3'd5, 3'd2, 7'b1000000};
    localparam logic [15:0] CMD_AND  = {3'b000, 3'd5, 3'd2, 7'b0000000};
    localparam logic [15:0] CMD_XOR  = {3'b001, 3'd5, 3'd2, 7'b0000000};
    localparam logic [15:0] CMD_BAD  = {3'b110, 3'd5, 3'd2, 7'b0000000};
    localparam logic [15:0] CMD_RMUL = {3'b011, 3'd5, 3'd2, 7'b0001000};
    localparam logic [15:0] CMD_RAND = {3'b000, 3'd7, 3'd0, 7'b0001000};
    localparam logic [15:0] CMD_X63  = {3'b001, 3'd6, 3'd3, 7'b0000000};
    localparam logic [15:0] CMD_A63  = {3'b000, 3'd6, 3'd3, 7'b0000000};

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs one command to completion; lat = posedges after accept until rsp valid (-1 on timeout)
    task automatic run_cmd(input int who, input logic [15:0] cmd, output logic [5:0] res,
                           output logic err, output int lat, output int drv,
                           output logic touched, output logic other);
        int n;
        lat = -1; drv = 0; touched = 1'b0; other = 1'b0; res = '0; err = 1'b0;
        @(negedge clk);
        if (who == 0) begin bus.req0_cmd = cmd; bus.req0_valid = 1'b1; end
        else          begin bus.req1_cmd = cmd; bus.req1_valid = 1'b1; end
        #1;
        n = 0;
        while (!((who == 0) ? bus.req0_ready : bus.req1_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) begin
            bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        n = 0;
        while (n < 20) begin
            if ({bus.alsu_opcode, bus.alsu_A, bus.alsu_B, bus.alsu_ctrl} == cmd) drv++;
            if (bus.alsu_opcode != '0 || bus.alsu_A != '0 || bus.alsu_B != '0 || bus.alsu_ctrl != '0)
                touched = 1'b1;
            if ((who == 0) ? bus.rsp1_valid : bus.rsp0_valid) other = 1'b1;
            if ((who == 0) ? bus.rsp0_valid : bus.rsp1_valid) break;
            @(negedge clk); n++;
        end
        if (n < 20) begin
            lat = n;
            res = (who == 0) ? bus.rsp0_result : bus.rsp1_result;
            err = (who == 0) ? bus.rsp0_err : bus.rsp1_err;
            if (who == 0) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.busy} !== 5'b0) begin
            fails++; $display("FAIL reset_flags: got %b expected 00000",
                {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.busy});
        end
        tests++;
        if ({bus.alsu_opcode, bus.alsu_A, bus.alsu_B, bus.alsu_ctrl} !== 16'h0) begin
            fails++; $display("FAIL reset_alsu: got %h expected 0000",
                {bus.alsu_opcode, bus.alsu_A, bus.alsu_B, bus.alsu_ctrl});
        end
        bus.req0_valid = 1'b1; bus.req0_cmd = CMD_ADD;
        #1;
        tests++;
        if (bus.req0_ready !== 1'b0) begin
            fails++; $display("FAIL reset_ready: got %b expected 0", bus.req0_ready);
        end
        bus.req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [5:0] res; logic err, touched, other; int lat, drv;
        run_cmd(0, CMD_ADD, res, err, lat, drv, touched, other);
        tests++; if (lat !== 3) begin fails++; $display("FAIL t1_latency: got %0d expected 3", lat); end
        tests++; if (drv !== 3) begin fails++; $display("FAIL t1_alsu_cycles: got %0d expected 3", drv); end
        tests++; if (res !== 6'd8) begin fails++; $display("FAIL t1_result: got %0d expected 8", res); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL t1_err: got %b expected 0", err); end
        tests++; if (other !== 1'b0) begin fails++; $display("FAIL t1_rsp1_quiet: got %b expected 0", other); end
    endtask

    task automatic test_round_robin();
        int n, g;
        do_reset();
        @(negedge clk);
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        bus.req0_cmd = CMD_AND; bus.req1_cmd = CMD_XOR;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin @(negedge clk); #1; n++; end
            g = bus.req1_ready ? 1 : (bus.req0_ready ? 0 : -1);
            tests++;
            if (g !== (k % 2)) begin fails++; $display("FAIL t2_grant%0d: got %0d expected %0d", k, g, k % 2); end
            @(negedge clk);
            n = 0;
            while (!(bus.rsp0_valid || bus.rsp1_valid) && n < 20) begin @(negedge clk); n++; end
            tests++;
            if (k % 2 == 0) begin
                if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 6'd0) begin
                    fails++; $display("FAIL t2_and%0d: got valid=%b res=%0d expected valid=1 res=0",
                        k, bus.rsp0_valid, bus.rsp0_result);
                end
            end else begin
                if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 6'd7) begin
                    fails++; $display("FAIL t2_xor%0d: got valid=%b res=%0d expected valid=1 res=7",
                        k, bus.rsp1_valid, bus.rsp1_result);
                end
            end
            @(negedge clk); #1;
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    endtask

    task automatic test_illegal();
        logic [5:0] res; logic err, touched, other; int lat, drv;
        run_cmd(1, CMD_BAD, res, err, lat, drv, touched, other);
        tests++; if (lat !== 0) begin fails++; $display("FAIL t3_latency: got %0d expected 0", lat); end
        tests++;
        if (res !== 6'd0 || err !== 1'b1) begin
            fails++; $display("FAIL t3_rsp: got res=%0d err=%b expected res=0 err=1", res, err);
        end
        tests++; if (touched !== 1'b0) begin fails++; $display("FAIL t3_alsu_idle: got %b expected 0", touched); end
    endtask

    task automatic test_red_op();
        logic [5:0] res; logic err, touched, other; int lat, drv;
        run_cmd(0, CMD_RMUL, res, err, lat, drv, touched, other);
        tests++;
        if (err !== 1'b1 || res !== 6'd0 || lat !== 0) begin
            fails++; $display("FAIL t4_red_illegal: got err=%b res=%0d lat=%0d expected err=1 res=0 lat=0",
                err, res, lat);
        end
        run_cmd(0, CMD_RAND, res, err, lat, drv, touched, other);
        tests++;
        if (err !== 1'b0 || res !== 6'd1 || lat !== 3) begin
            fails++; $display("FAIL t4_red_and: got err=%b res=%0d lat=%0d expected err=0 res=1 lat=3",
                err, res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        bus.req0_cmd = CMD_X63; bus.req0_valid = 1'b1;
        #1;
        tests++; if (bus.req0_ready !== 1'b1) begin fails++; $display("FAIL t5_grant0: got %b expected 1", bus.req0_ready); end
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_cmd = CMD_A63; bus.req1_valid = 1'b1;
        n = 0;
        while (!bus.rsp0_valid && n < 20) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if ({bus.rsp0_valid, bus.rsp0_result, bus.rsp0_err, bus.req1_ready, bus.busy} !== {1'b1, 6'd5, 1'b0, 1'b0, 1'b1}) begin
                fails++; $display("FAIL t5_hold%0d: got valid=%b res=%0d err=%b r1rdy=%b busy=%b expected 1 5 0 0 1",
                    k, bus.rsp0_valid, bus.rsp0_result, bus.rsp0_err, bus.req1_ready, bus.busy);
            end
            @(negedge clk);
        end
        bus.rsp0_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        #1;
        tests++;
        if (bus.req1_ready !== 1'b1 || bus.rsp0_valid !== 1'b0) begin
            fails++; $display("FAIL t5_grant1: got r1rdy=%b rsp0=%b expected 1 0", bus.req1_ready, bus.rsp0_valid);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        n = 0;
        while (!bus.rsp1_valid && n < 20) begin @(negedge clk); n++; end
        tests++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 6'd2) begin
            fails++; $display("FAIL t5_rsp1: got valid=%b res=%0d expected 1 2", bus.rsp1_valid, bus.rsp1_result);
        end
        bus.rsp1_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp1_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n; logic seen;
        do_reset();
        @(negedge clk);
        bus.req0_cmd = CMD_ADD; bus.req0_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req1_cmd = CMD_XOR; bus.req1_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if ({bus.busy, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== 5'b0) begin
            fails++; $display("FAIL t6_flags: got %b expected 00000",
                {bus.busy, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid});
        end
        tests++;
        if ({bus.alsu_opcode, bus.alsu_A, bus.alsu_B, bus.alsu_ctrl} !== 16'h0) begin
            fails++; $display("FAIL t6_alsu: got %h expected 0000",
                {bus.alsu_opcode, bus.alsu_A, bus.alsu_B, bus.alsu_ctrl});
        end
        @(negedge clk);
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus.rsp0_valid || bus.rsp1_valid) seen = 1'b1;
            @(negedge clk);
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL t6_no_rsp: got %b expected 0", seen); end
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        tests++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            fails++; $display("FAIL t6_tie: got r0=%b r1=%b expected 1 0", bus.req0_ready, bus.req1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        n = 0;
        while (!bus.rsp0_valid && n < 20) begin @(negedge clk); n++; end
        tests++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 6'd8) begin
            fails++; $display("FAIL t6_rsp: got valid=%b res=%0d expected 1 8", bus.rsp0_valid, bus.rsp0_result);
        end
        bus.rsp0_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_cmd = '0;
        bus.req1_valid = 1'b0; bus.req1_cmd = '0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_illegal();
        test_red_op();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
